seg_display_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment driver: takes a binary value and renders it on DIGITS static active-low displays.
- Supports decimal (signed/unsigned), hex, leading-zero blanking, a per-digit decimal-point mask, overflow indication and blink.
- Decimal conversion is iterative (shift-add-3), one bit per clock, behind a load/busy/done handshake.
- Sits between the datapath and the board HEX outputs.

---
 rtl/seg_pkg.sv | 58 +++++
 rtl/bin2bcd_iter.sv | 60 ++++++
 rtl/seg_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display controller: active-low glyphs,
// controller state encoding and small helper functions.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // AND mask that lights the decimal point (bit 7 is active-low).
  localparam logic [7:0] SEG_DP_N  = 8'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT
  } state_e;

  function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  // ceil(w * log10(2)) in integer arithmetic; exact for the supported widths.
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per clock.
// done_o is high during the cycle whose closing edge performs the final shift.
module bin2bcd_iter
  import seg_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [WIDTH-1:0]        bin_i,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int SRW = 4 * BCD_DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH + 1);

  logic [SRW-1:0] sr_q, sr_d, adj;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    adj   = sr_q;
    sr_d  = sr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (sr_q[WIDTH+4*d +: 4] >= 4'd5) adj[WIDTH+4*d +: 4] = sr_q[WIDTH+4*d +: 4] + 4'd3;
    end
    if (start_i) begin
      sr_d  = SRW'(bin_i);
      cnt_d = CW'(WIDTH);
      run_d = 1'b1;
    end else if (run_q) begin
      sr_d  = {adj[SRW-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      run_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == CW'(1));
  assign bcd_o  = sr_q[SRW-1:WIDTH];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit active-low seven-segment driver: captures a value on load, converts
// it (decimal or hex), formats the glyph pattern, commits it and applies blink.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int WIDTH     = 16,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  is_signed,
  input  logic                  hex_mode,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   hex_out
);

  localparam int BCD_DIGITS = bcd_digits(WIDTH);
  localparam int NIBBLES    = (WIDTH + 3) / 4;
  localparam int DPAD       = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
  localparam int BEXT       = 4 * DPAD;
  localparam int VEXT       = 4 * (DIGITS + NIBBLES);
  localparam int BCW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_e                  state_q, state_d;
  logic                    built_q, built_d;
  logic                    accept, commit;
  logic                    neg_in, neg_q, hex_q, done_q;
  logic [WIDTH-1:0]        mag, value_q;
  logic [DIGITS-1:0]       dp_q;
  logic [8*DIGITS-1:0]     pat_d, pat_q, disp_q;
  logic                    conv_last;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [BEXT-1:0]         bcd_ext;
  logic [VEXT-1:0]         vext;
  int                      nsig;
  logic                    ovf;
  logic [7:0]              glyph;
  logic [BCW-1:0]          blink_cnt_q;
  logic                    blink_on_q;

  // Negation is held WIDTH bits unsigned, so the most negative input stays exact.
  assign neg_in = is_signed & value[WIDTH-1] & ~hex_mode;
  assign mag    = neg_in ? (~value + 1'b1) : value;

  bin2bcd_iter #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept & ~hex_mode),
    .bin_i   (mag),
    .done_o  (conv_last),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d = state_q;
    built_d = built_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          accept  = 1'b1;
          built_d = 1'b0;
          state_d = hex_mode ? FORMAT : CONVERT;
        end
      end
      CONVERT: if (conv_last) state_d = FORMAT;
      FORMAT: begin
        // First FORMAT cycle registers the pattern; the second commits it.
        if (!built_q) begin
          built_d = 1'b1;
        end else begin
          commit  = 1'b1;
          built_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_ext = BEXT'(bcd);
    vext    = VEXT'(value_q);
    nsig    = 1;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) nsig = i + 1;
    end
    if (hex_q) ovf = |(vext >> (4 * DIGITS));
    else       ovf = (nsig + int'(neg_q)) > DIGITS;
    pat_d = '1;
    glyph = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (hex_q)                     glyph = (i < NIBBLES) ? nibble_to_seg(vext[4*i +: 4]) : SEG_BLANK;
      else if (i < nsig)             glyph = nibble_to_seg(bcd_ext[4*i +: 4]);
      else if (neg_q && (i == nsig)) glyph = SEG_MINUS;
      else                           glyph = SEG_BLANK;
      if (ovf)           glyph = SEG_F;
      else if (dp_q[i])  glyph = glyph & SEG_DP_N;
      pat_d[8*i +: 8] = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      built_q <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
      neg_q   <= 1'b0;
      hex_q   <= 1'b0;
      dp_q    <= '0;
      pat_q   <= '1;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      built_q <= built_d;
      done_q  <= commit;
      if (accept) begin
        value_q <= value;
        neg_q   <= neg_in;
        hex_q   <= hex_mode;
        dp_q    <= dp_mask;
      end
      if (state_q == FORMAT && !built_q) pat_q <= pat_d;
      if (commit) disp_q <= pat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign hex_out = (blink_en && !blink_on_q) ? '1 : disp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench: a 6-digit and a 4-digit display share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_seg_display_ctrl;

  localparam int W   = 16;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset, load, is_signed, hex_mode, blink_en;
  logic [15:0] value;
  logic [5:0]  dp_mask;
  logic        busy6, done6, busy4, done4;
  logic [47:0] hex6;
  logic [31:0] hex4;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  logic [63:0] cur6, cur4;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_display_ctrl #(.DIGITS(6), .WIDTH(W), .BLINK_DIV(DIV)) u_dut6 (
    .clk(clk), .reset(reset), .load(load), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .dp_mask(dp_mask), .blink_en(blink_en),
    .busy(busy6), .done(done6), .hex_out(hex6)
  );

  seg_display_ctrl #(.DIGITS(4), .WIDTH(W), .BLINK_DIV(DIV)) u_dut4 (
    .clk(clk), .reset(reset), .load(load), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .dp_mask(dp_mask[3:0]), .blink_en(blink_en),
    .busy(busy4), .done(done4), .hex_out(hex4)
  );

  always #5 clk = ~clk;

  // Non-reset edges since the last reset; the blink phase follows from this count.
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [15:0] v, input bit s, input bit h,
                                        input logic [7:0] dp, input int nd);
    logic [63:0] r;
    logic [7:0]  g;
    int          dig [8];
    int          nsig;
    longint      m;
    bit          neg, ovf;
    r    = '0;
    nsig = 0;
    neg  = 1'b0;
    m    = longint'(v);
    if (!h) begin
      neg = s && v[15];
      if (neg) m = 65536 - m;
      do begin
        dig[nsig] = int'(m % 10);
        m = m / 10;
        nsig++;
      end while (m > 0);
      ovf = (nsig + int'(neg)) > nd;
    end else begin
      ovf = (nd < 4) && ((v >> (4 * nd)) != 16'd0);
    end
    for (int i = 0; i < nd; i++) begin
      if (h)                 g = (i < 4) ? glyph_tab[(v >> (4 * i)) & 16'hF] : 8'hFF;
      else if (i < nsig)     g = glyph_tab[dig[i]];
      else if (neg && i == nsig) g = 8'hBF;
      else                   g = 8'hFF;
      if (ovf)        g = 8'h8E;
      else if (dp[i]) g[7] = 1'b0;
      r[8*i +: 8] = g;
    end
    return r;
  endfunction

  // Called at a negedge with the DUTs idle; returns at a negedge one cycle after done.
  task automatic run_txn(input logic [15:0] v, input bit s, input bit h,
                         input logic [5:0] dp, input int glitch_at);
    logic [63:0] e6, e4;
    int n, busy_cnt, lat;
    bit hold_ok, got;
    e6 = model(v, s, h, {2'b0, dp}, 6);
    e4 = model(v, s, h, {4'b0, dp[3:0]}, 4);
    lat = h ? 2 : W + 2;
    value = v; is_signed = s; hex_mode = h; dp_mask = dp; load = 1'b1;
    @(posedge clk);
    #1;
    load      = 1'b0;
    value     = 16'($urandom);
    is_signed = 1'($urandom);
    hex_mode  = 1'($urandom);
    dp_mask   = 6'($urandom);
    n = 0; busy_cnt = 0; hold_ok = 1'b1; got = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      load = (n == glitch_at);
      if (done6) begin
        got = 1'b1;
        break;
      end
      if (busy6 && busy4) busy_cnt++;
      if (64'(hex6) !== cur6 || 64'(hex4) !== cur4) hold_ok = 1'b0;
      n++;
    end
    load = 1'b0;
    check("done_seen", got, 1'b1);
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(busy_cnt), 64'(lat));
    check("done4_sync", done4, 1'b1);
    check("hold_until_commit", hold_ok, 1'b1);
    check("hex6", 64'(hex6), e6);
    check("hex4", 64'(hex4), e4);
    cur6 = e6;
    cur4 = e4;
    @(negedge clk);
    check("done_one_cycle", {done6, done4}, 2'b00);
    check("busy_after_commit", {busy6, busy4}, 2'b00);
  endtask

  initial begin
    logic [15:0] rv;
    bit ok;
    reset = 1'b1; load = 1'b0; value = '0; is_signed = 1'b0; hex_mode = 1'b0;
    dp_mask = '0; blink_en = 1'b0;
    cur6 = 64'h0000_FFFF_FFFF_FFFF;
    cur4 = 64'h0000_0000_FFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hex6", 64'(hex6), cur6);
    check("reset_hex4", 64'(hex4), cur4);
    check("reset_busy_done", {busy6, done6, busy4, done4}, 4'b0000);
    reset = 1'b0;

    run_txn(16'd1234, 1'b0, 1'b0, 6'b0, -1);
    check("dec1234_const", 64'(hex6), 64'hFFFF_F9A4_B099);
    run_txn(16'hFFD6, 1'b1, 1'b0, 6'b0, -1);
    check("neg42_const", 64'(hex6), 64'hFFFF_FFBF_99A4);
    run_txn(16'h8000, 1'b1, 1'b0, 6'b0, -1);
    check("most_neg_const", 64'(hex6), 64'hBFB0_A4F8_8280);
    check("most_neg_ovf4", 64'(hex4), 64'h8E8E_8E8E);
    run_txn(16'h00AF, 1'b0, 1'b1, 6'b000001, -1);
    check("hex00af_const", 64'(hex6), 64'hFFFF_C0C0_880E);
    run_txn(16'd12345, 1'b0, 1'b0, 6'b111111, -1);
    check("ovf4_const", 64'(hex4), 64'h8E8E_8E8E);
    run_txn(16'd0, 1'b1, 1'b0, 6'b0, -1);
    check("zero_const", 64'(hex4), 64'hFFFF_FFC0);
    run_txn(16'd7, 1'b0, 1'b0, 6'b100010, -1);
    run_txn(16'hFFFF, 1'b1, 1'b1, 6'b0, -1);
    run_txn(16'd4321, 1'b0, 1'b0, 6'b0, 5);

    // Reset in the middle of a decimal conversion.
    value = 16'd999; is_signed = 1'b0; hex_mode = 1'b0; dp_mask = '0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    cur6 = 64'h0000_FFFF_FFFF_FFFF;
    cur4 = 64'h0000_0000_FFFF_FFFF;
    @(negedge clk);
    check("abort_hex6", 64'(hex6), cur6);
    check("abort_hex4", 64'(hex4), cur4);
    check("abort_busy", {busy6, busy4}, 2'b00);
    ok = 1'b1;
    repeat (W + 6) begin
      @(negedge clk);
      if (done6 || done4 || busy6) ok = 1'b0;
    end
    check("abort_no_done", ok, 1'b1);
    run_txn(16'd65535, 1'b0, 1'b0, 6'b000100, -1);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'($urandom_range(0, 99));
        1:       rv = 16'($urandom_range(0, 9999));
        2:       rv = 16'($urandom);
        default: rv = 16'(-$urandom_range(1, 999));
      endcase
      run_txn(rv, 1'($urandom), 1'($urandom), 6'($urandom), -1);
    end

    // Blink over a stored pattern.
    run_txn(16'hFF85, 1'b1, 1'b0, 6'b000010, -1);
    blink_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("blink6", 64'(hex6), ((edges / DIV) % 2 == 0) ? cur6 : 64'h0000_FFFF_FFFF_FFFF);
      check("blink4", 64'(hex4), ((edges / DIV) % 2 == 0) ? cur4 : 64'h0000_0000_FFFF_FFFF);
    end
    ok = 1'b0;
    for (int t = 0; t < 2 * DIV + 2; t++) begin
      if ((edges / DIV) % 2 == 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("blink_off_phase_found", ok, 1'b1);
    check("blink_off_all_ff", 64'(hex6), 64'h0000_FFFF_FFFF_FFFF);
    blink_en = 1'b0;
    @(negedge clk);
    check("unblink6", 64'(hex6), cur6);
    check("unblink4", 64'(hex4), cur4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
